// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR fetch stage with jump folding, redirect flush and self-loop halt detection
module instr_fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter logic [2:0] JMP_OP   = 3'b111,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [7:0]       addr,
   input  logic [20:0]      instruction,
   output logic [20:0]      ir,
   output logic [7:0]       ir_pc,
   output logic             ir_valid,
   input  logic             ir_ready,
   input  logic             redirect,
   input  logic [7:0]       redirect_addr,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_cnt
);
   typedef enum logic {st_run, st_halt} state_t;
   state_t state, state_nxt;
   logic [7:0] pc;
   logic advance, is_jmp, self_jmp;
   assign addr     = pc;
   assign advance  = (state == st_run) && (!ir_valid || ir_ready);
   assign is_jmp   = instruction[20:18] == JMP_OP;
   assign self_jmp = is_jmp && (instruction[7:0] == pc);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= st_run;
      else state <= state_nxt;
   always_comb
      state_nxt = redirect ? st_run : (advance && self_jmp) ? st_halt : state;
   always_comb
      halted = state == st_halt;
   // A folded jump steers the PC on the same edge the jump enters IR, so no bubble
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pc        <= RESET_PC;
         ir        <= '0;
         ir_pc     <= '0;
         ir_valid  <= 1'b0;
         fetch_cnt <= '0;
      end else if (redirect) begin
         pc       <= redirect_addr;
         ir_valid <= 1'b0;
      end else if (advance) begin
         ir        <= instruction;
         ir_pc     <= pc;
         ir_valid  <= 1'b1;
         fetch_cnt <= &fetch_cnt ? fetch_cnt : fetch_cnt + CNT_W'(1);
         pc        <= is_jmp ? instruction[7:0] : pc + 8'd1;
      end else if (state == st_halt && ir_ready) begin
         ir_valid <= 1'b0;
      end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus against a ROM image with an architectural fetch model
module tb_instr_fetch_unit;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam logic [20:0] I00 = 21'b001011100000000000000;
   localparam logic [20:0] J03 = 21'b111000001101100000001;
   localparam logic [20:0] J09 = 21'b111000000000000001001;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [7:0] addr, ir_pc, redirect_addr = 8'h00;
   logic [20:0] instruction, ir;
   logic ir_valid, halted, ir_ready = 1'b1, redirect = 1'b0;
   logic [CNT_W-1:0] fetch_cnt;
   logic [20:0] rom [256];
   int n_chk = 0, n_fail = 0;
   logic [7:0] m_pc, m_ir_pc;
   logic [20:0] m_ir, w;
   logic m_valid, m_halt;
   int m_cnt;
   instr_fetch_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .instruction(instruction), .ir(ir),
      .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready), .redirect(redirect),
      .redirect_addr(redirect_addr), .halted(halted), .fetch_cnt(fetch_cnt)
   );
   assign instruction = rom[addr];
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Model: what the fetch stage must hold after each edge, from the architectural rules
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_pc = 8'h00; m_ir = '0; m_ir_pc = '0; m_valid = 0; m_halt = 0; m_cnt = 0;
      end else if (redirect) begin
         m_pc = redirect_addr; m_valid = 0; m_halt = 0;
      end else if (!m_halt && (!m_valid || ir_ready)) begin
         w = rom[m_pc];
         m_ir = w; m_ir_pc = m_pc; m_valid = 1;
         m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
         if (w[20:18] == 3'b111) begin
            if (w[7:0] == m_pc) m_halt = 1;
            m_pc = w[7:0];
         end else m_pc = m_pc + 8'd1;
      end else if (m_halt && ir_ready) m_valid = 0;
   always @(negedge clk) begin
      chk("addr", 32'(addr), 32'(m_pc));
      chk("ir", 32'(ir), 32'(m_ir));
      chk("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
      chk("ir_valid", 32'(ir_valid), 32'(m_valid));
      chk("halted", 32'(halted), 32'(m_halt));
      chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
   end
   task automatic nx;
      @(negedge clk);
   endtask
   initial begin
      logic [7:0] seq [7];
      seq = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h01};
      for (int i = 0; i < 256; i++) rom[i] = {3'b010, 10'(i), 8'(i)};
      rom[0] = I00; rom[3] = J03; rom[9] = J09;
      nx; chk("reset addr", 32'(addr), 32'h00);
      chk("reset ir_valid", 32'(ir_valid), 32'h0);
      nx; rst_n = 1'b1;
      nx; chk("first ir", 32'(ir), 32'(I00));
      chk("first ir_pc", 32'(ir_pc), 32'h00);
      chk("first valid", 32'(ir_valid), 32'h1);
      chk("first addr", 32'(addr), 32'h01);
      for (int i = 0; i < 7; i++) begin
         nx; chk("seq ir_pc", 32'(ir_pc), 32'(seq[i]));
         chk("seq cnt", 32'(fetch_cnt), 32'(i + 2));
      end
      ir_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         nx; chk("stall ir_pc", 32'(ir_pc), 32'h01);
         chk("stall addr", 32'(addr), 32'h02);
         chk("stall cnt", 32'(fetch_cnt), 32'd8);
      end
      ir_ready = 1'b1;
      nx; chk("resume ir_pc", 32'(ir_pc), 32'h02);
      nx; chk("resume ir_pc2", 32'(ir_pc), 32'h03);
      chk("resume cnt", 32'(fetch_cnt), 32'd10);
      ir_ready = 1'b0; redirect = 1'b1; redirect_addr = 8'h05;
      nx; chk("flush valid", 32'(ir_valid), 32'h0);
      chk("flush addr", 32'(addr), 32'h05);
      redirect = 1'b0; ir_ready = 1'b1;
      nx; chk("redir ir_pc", 32'(ir_pc), 32'h05);
      chk("redir cnt", 32'(fetch_cnt), 32'd11);
      redirect = 1'b1; redirect_addr = 8'h09; ir_ready = 1'b0;
      nx; chk("r9 valid", 32'(ir_valid), 32'h0);
      redirect = 1'b0;
      nx; chk("r9 ir", 32'(ir), 32'(J09));
      chk("r9 ir_pc", 32'(ir_pc), 32'h09);
      chk("r9 halted", 32'(halted), 32'h1);
      repeat (2) begin
         nx; chk("halt hold valid", 32'(ir_valid), 32'h1);
         chk("halt addr", 32'(addr), 32'h09);
         chk("halt cnt", 32'(fetch_cnt), 32'd12);
      end
      ir_ready = 1'b1;
      repeat (2) begin
         nx; chk("halt drained", 32'(ir_valid), 32'h0);
         chk("halt still", 32'(halted), 32'h1);
         chk("halt cnt2", 32'(fetch_cnt), 32'd12);
      end
      redirect = 1'b1; redirect_addr = 8'h04;
      nx; chk("unhalt", 32'(halted), 32'h0);
      chk("unhalt addr", 32'(addr), 32'h04);
      redirect = 1'b0;
      nx; chk("r4 ir_pc", 32'(ir_pc), 32'h04);
      redirect = 1'b1; redirect_addr = 8'hFF;
      nx; chk("rff addr", 32'(addr), 32'hFF);
      redirect = 1'b0;
      nx; chk("rff ir_pc", 32'(ir_pc), 32'hFF);
      chk("wrap addr", 32'(addr), 32'h00);
      nx; chk("wrap ir_pc", 32'(ir_pc), 32'h00);
      chk("wrap ir", 32'(ir), 32'(I00));
      repeat (2) nx;
      chk("sat cnt", 32'(fetch_cnt), 32'(CMAX));
      #2 rst_n = 1'b0;
      #1 chk("async addr", 32'(addr), 32'h00);
      chk("async ir", 32'(ir), 32'h0);
      chk("async valid", 32'(ir_valid), 32'h0);
      chk("async cnt", 32'(fetch_cnt), 32'h0);
      nx; nx; rst_n = 1'b1;
      nx; chk("rerun ir_pc", 32'(ir_pc), 32'h00);
      chk("rerun cnt", 32'(fetch_cnt), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the 256 x 21-bit instruction ROM.
- Holds the program counter and drives the ROM address.
- Captures the combinational ROM word into an instruction register.
- Presents that word to decode over a valid/ready handshake.
- Folds unconditional jumps locally, accepts redirects from execute, and detects the self-loop halt idiom.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
JMP_OP, 3'b111, opcode in INSTRUCTION[20:18] marking an unconditional jump; target is INSTRUCTION[7:0].
CNT_W, 16, width of the fetch performance counter.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST_N  input  1  asynchronous active-low reset.
ADDR  output  8  ROM address; combinationally equal to the PC register.
INSTRUCTION  input  21  ROM data for ADDR, valid in the same cycle.
IR  output  21  registered instruction presented to decode.
IR_PC  output  8  address IR was fetched from.
IR_VALID  output  1  IR holds an instruction not yet consumed.
IR_READY  input  1  decode accepts IR this cycle.
REDIRECT  input  1  execute-stage redirect (taken branch, trap).
REDIRECT_ADDR  input  8  new PC when REDIRECT=1.
HALTED  output  1  fetch is parked on a self-loop jump.
FETCH_CNT  output  CNT_W  number of words written into IR since reset; saturates.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - PC=RESET_PC, so ADDR=RESET_PC.
  - IR=0, IR_PC=0, IR_VALID=0, HALTED=0, FETCH_CNT=0.
  - State=RUN.
  - Deassertion is taken on the next CLK edge; the first fetch happens on the first edge with RST_N=1.
- States:
  - RUN: fetching.
  - HALTED: no fetches; the HALTED output is 1.
- advance = (state==RUN) && (!IR_VALID || IR_READY).
- Priority each edge, highest first:
  1. REDIRECT=1, any state:
     - PC<=REDIRECT_ADDR, IR_VALID<=0 (flush, even if IR_READY=0), state<=RUN.
     - No IR write and no FETCH_CNT increment that cycle.
     - The redirected word appears in IR one edge later, so redirect-to-IR_VALID latency is 2 edges.
  2. advance=1:
     - IR<=INSTRUCTION, IR_PC<=PC, IR_VALID<=1, FETCH_CNT<=FETCH_CNT+1 (holds at all-ones).
     - If INSTRUCTION[20:18]==JMP_OP: PC<=INSTRUCTION[7:0] (zero-bubble jump fold).
     - Otherwise PC<=PC+1, modulo 256 (8'hFF wraps to 8'h00).
     - If it is a jump and INSTRUCTION[7:0]==PC: state<=HALTED. The self-jump is still delivered to IR once; PC is unchanged.
  3. IR_VALID=1 && IR_READY=0: IR, IR_PC, IR_VALID and PC hold (backpressure).
  4. In HALTED with IR_READY=1: IR_VALID<=0 once the final jump is consumed. IR keeps its last value; PC holds.
- Handshake:
  - Transfer happens when IR_VALID && IR_READY at an edge.
  - IR is stable while IR_VALID=1 and IR_READY=0.
  - Fetch replaces IR on the same edge as a transfer, sustaining 1 instruction per cycle.
- IR_PC is the fetch address of IR, never the post-increment PC.
- Only REDIRECT and reset leave HALTED.
- Reset mid-operation overrides everything asynchronously, including an in-flight redirect or backpressure.

Test Plan:
1. Reset then release, IR_READY=1 -> ADDR=8'h00 during reset; after the first edge IR=i00=21'b001011100000000000000, IR_PC=0, IR_VALID=1, ADDR=8'h01.
2. ROM loaded with the production image, IR_READY=1:
   - IR_PC sequence is 00,01,02,03,01,02,03...
   - The jump at 8'h03 (word 21'b111000001101100000001) redirects to 8'h01 with no bubble cycle.
   - FETCH_CNT increments every edge.
3. REDIRECT=1 with REDIRECT_ADDR=8'h09 while running:
   - Next edge: IR_VALID=0. Following edge: IR=21'b111000000000000001001, IR_PC=8'h09.
   - Next cycle HALTED=1, ADDR stays 8'h09, FETCH_CNT stops.
   - After IR_READY, IR_VALID=0.
   - A subsequent REDIRECT to 8'h04 clears HALTED, and IR_PC=8'h04 two edges later.
4. Hold IR_READY=0 for 5 cycles mid-stream -> IR, IR_PC and ADDR frozen; FETCH_CNT frozen. Raising IR_READY resumes with no lost or duplicated IR_PC.
5. IR_READY=0 with REDIRECT=1 on the same edge -> IR_VALID=0 next cycle, ADDR=REDIRECT_ADDR; the stale IR is never transferred.
6. Redirect to 8'hFF where the ROM word there is not a jump -> IR_PC=8'hFF, then 8'h00 (wrap). Pulse RST_N low mid-stream -> outputs go to reset values immediately, without waiting for a CLK edge.
